aes128_round_ctrl: RTL and testbench

Iterative AES-128 encryption controller. It sequences one 128-bit state register through the initial AddRoundKey and ten rounds: SubBytes, ShiftRows, the existing registered `mix_columns` stage (rounds 1-9 only) and AddRoundKey. It expands the round keys on the fly. It sits between a valid/ready block source and a valid/ready ciphertext sink, and owns the single shared `mix_columns` instance.

---
 rtl/aes128_round_ctrl_if.sv | 31 +++
 rtl/aes128_round_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_aes128_round_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_round_ctrl_if.sv
// Block-in / ciphertext-out valid/ready bundle for the
// iterative AES-128 round controller.
interface aes128_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  modport master (
    output in_valid,
    output plaintext,
    output key,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  ciphertext
  );

  modport slave (
    input  in_valid,
    input  plaintext,
    input  key,
    input  out_ready,
    output in_ready,
    output out_valid,
    output ciphertext
  );
endinterface

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryptor: one state register, on-the-fly
// key expansion, shared registered MixColumns stage.
module mix_columns (
  input  logic         clk,
  input  logic         en_i,
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  logic [127:0] mc_q;

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0}
         ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(
    input logic [31:0] c
  );
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {
      xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
      xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
    };
  endfunction

  always_ff @(posedge clk) begin
    if (en_i) begin
      mc_q <= {mix_col(state_i[127:96]),
               mix_col(state_i[95:64]),
               mix_col(state_i[63:32]),
               mix_col(state_i[31:0])};
    end
  end

  assign state_o = mc_q;
endmodule

module aes128_round_ctrl (
  input  logic               clk,
  input  logic               rst,
  aes128_round_ctrl_if.slave bus,
  output logic               busy,
  output logic [3:0]         round
);
  typedef enum logic [2:0] {
    IDLE, SB, MC, ARK, DONE
  } fsm_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] mc_out;
  logic         mc_en;
  logic         idle;
  logic         done;
  logic         last;

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX[b];
  endfunction

  function automatic logic [127:0] sub_shift(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    // SubWord(RotWord(w3)) with rcon on the lead byte
    t = {sbox(w3[23:16]) ^ rc,
         sbox(w3[15:8]),
         sbox(w3[7:0]),
         sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  mix_columns u_mc (
    .clk     (clk),
    .en_i    (mc_en),
    .state_i (state_q),
    .state_o (mc_out)
  );

  assign last = (round_q == 4'd10);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE: if (bus.in_valid) fsm_d = SB;
      SB:   fsm_d = last ? ARK : MC;
      MC:   fsm_d = ARK;
      ARK:  fsm_d = last ? DONE : SB;
      DONE: if (bus.out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    idle  = 1'b0;
    done  = 1'b0;
    busy  = 1'b0;
    mc_en = 1'b0;
    unique case (1'b1)
      fsm_q == IDLE: idle = 1'b1;
      fsm_q == DONE: done = 1'b1;
      fsm_q == MC: begin
        busy  = 1'b1;
        mc_en = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.plaintext ^ bus.key;
          key_d   = bus.key;
          round_d = 4'd1;
        end
      end
      SB: begin
        state_d = sub_shift(state_q);
        key_d   = expand(key_q, rcon(round_q));
      end
      ARK: begin
        state_d = (last ? state_q : mc_out) ^ key_q;
        if (!last) round_d = round_q + 4'd1;
      end
      DONE: if (bus.out_ready) round_d = '0;
      default: ;
    endcase
  end

  assign bus.in_ready   = idle && !rst;
  assign bus.out_valid  = done;
  assign bus.ciphertext = state_q;
  assign round          = round_q;
endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Scoreboard bench for aes128_round_ctrl: FIPS-197 vectors,
// backpressure, back-to-back, and reset interactions.
module tb_aes128_round_ctrl;
  localparam logic [127:0] PT_B =
    128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B =
    128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R1_C =
    128'h89d810e8855ace682d1843d8cb128fe4;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  logic clk;
  logic rst;
  logic busy;
  logic [3:0] round;
  int   cyc;
  int   checks;
  int   errors;
  int   hs_cnt;
  logic ov_q;
  exp_t sb[$];

  aes128_round_ctrl_if bus ();

  aes128_round_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .round (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ref_ct(
    input logic [127:0] p,
    input logic [127:0] k
  );
    if (p == PT_B && k == K_B) return CT_B;
    if (p == PT_C && k == K_C) return CT_C;
    return '0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      ov_q = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        e.ct  = ref_ct(bus.plaintext, bus.key);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      if (bus.out_valid && !ov_q) begin
        if (sb.size() == 0)
          check("spurious_ov", 128'd1, 128'd0);
        else
          check("latency", 128'(cyc - sb[0].acc),
                128'd29);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_hs", 128'd1, 128'd0);
        end else begin
          e = sb.pop_front();
          check("ct", bus.ciphertext, e.ct);
        end
        hs_cnt++;
      end
      ov_q = bus.out_valid;
    end
  end

  task automatic wait_acc(output int e);
    e = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready && bus.in_valid) begin
        @(posedge clk);
        #1;
        e = cyc;
        break;
      end
    end
    if (e < 0) check("acc_timeout", 128'd1, 128'd0);
  endtask

  task automatic send(
    input  logic [127:0] p,
    input  logic [127:0] k,
    output int           e
  );
    bus.plaintext = p;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    wait_acc(e);
    bus.in_valid  = 1'b0;
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 300; i++) begin
      if (hs_cnt >= n) break;
      @(posedge clk);
      #1;
    end
    if (hs_cnt < n) check("hs_timeout", 128'd1, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation hung");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, r;
    logic [127:0] ct0;
    checks        = 0;
    errors        = 0;
    hs_cnt        = 0;
    ov_q          = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.plaintext = '0;
    bus.key       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'd0);
    check("rst_ov", 128'(bus.out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_round", 128'(round), 128'd0);
    check("rst_ct", bus.ciphertext, 128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_rdy", 128'(bus.in_ready), 128'd1);

    send(PT_B, K_B, a1);
    check("b_busy", 128'(busy), 128'd1);
    check("b_round", 128'(round), 128'd1);
    wait_hs(1);

    send(PT_C, K_C, a1);
    repeat (3) @(posedge clk);
    #1;
    check("c1_r1_state", bus.ciphertext, R1_C);
    check("c1_r1_round", 128'(round), 128'd2);
    wait_hs(2);

    bus.out_ready = 1'b0;
    send(PT_B, K_B, a1);
    for (int i = 0; i < 100 && !bus.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("bp_ov_seen", 128'(bus.out_valid), 128'd1);
    check("bp_round", 128'(round), 128'd10);
    ct0 = bus.ciphertext;
    check("bp_ct_first", ct0, CT_B);
    for (int i = 0; i < 50; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.plaintext = {$urandom, $urandom,
                       $urandom, $urandom};
      bus.key       = {$urandom, $urandom,
                       $urandom, $urandom};
      @(posedge clk);
      #1;
      check("bp_ct", bus.ciphertext, ct0);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      check("bp_ov", 128'(bus.out_valid), 128'd1);
    end
    check("bp_no_hs", 128'(hs_cnt), 128'd2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_one_hs", 128'(hs_cnt), 128'd3);
    check("bp_rdy_after", 128'(bus.in_ready), 128'd1);
    check("bp_ov_drop", 128'(bus.out_valid), 128'd0);
    check("bp_round0", 128'(round), 128'd0);
    @(posedge clk);
    #1;
    check("bp_hs_once", 128'(hs_cnt), 128'd3);

    bus.plaintext = PT_B;
    bus.key       = K_B;
    bus.in_valid  = 1'b1;
    wait_acc(a1);
    bus.plaintext = PT_C;
    bus.key       = K_C;
    wait_acc(a2);
    bus.in_valid  = 1'b0;
    check("b2b_gap", 128'(a2 - a1), 128'd31);
    wait_hs(5);

    send(PT_B, K_B, a1);
    repeat (13) @(posedge clk);
    #1;
    check("r5_round", 128'(round), 128'd5);
    check("r5_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("r5_ov", 128'(bus.out_valid), 128'd0);
    check("r5_round0", 128'(round), 128'd0);
    check("r5_ct", bus.ciphertext, 128'd0);
    check("r5_busy0", 128'(busy), 128'd0);
    rst = 1'b0;
    #1;
    check("r5_idle", 128'(bus.in_ready), 128'd1);
    check("r5_no_hs", 128'(hs_cnt), 128'd5);
    send(PT_B, K_B, a1);
    wait_hs(6);

    rst           = 1'b1;
    bus.plaintext = PT_B;
    bus.key       = K_B;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    check("ra_busy", 128'(busy), 128'd0);
    check("ra_round", 128'(round), 128'd0);
    rst = 1'b0;
    r   = cyc;
    wait_acc(a1);
    bus.in_valid = 1'b0;
    check("ra_acc_edge", 128'(a1), 128'(r + 1));
    check("ra_busy_on", 128'(busy), 128'd1);
    wait_hs(7);
    check("hs_total", 128'(hs_cnt), 128'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
